// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the CPU memory interface and
// a program loader / debug port. One access is in flight at a time; the CPU
// has fixed priority. Each access takes three cycles: grant decision (IDLE),
// RAM strobe (ACC) and completion pulse (DONE).
//
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN):
//   When defined, a run counter limits the number of consecutive CPU grants
//   while the loader is waiting to MAX_CPU_RUN; the next grant is then forced
//   to the loader. When undefined, the loader is served only when the CPU is
//   not requesting in IDLE.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     CPU command, held stable until cpu_ready
//   cpu_rdata                 CPU read data, valid with cpu_ready, held after
//   cpu_ready                 one-cycle completion pulse to the CPU
//   cpu_stall                 cpu_req & ~cpu_ready, holds controller states
//   ldr_*                     loader mirror of the cpu_* command/response
//   ram_en/we/addr/wdata      RAM command (ram_we only together with ram_en)
//   ram_rdata                 RAM read data, one cycle after the ram_en cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int RAM_SIZE  = 1024,
`ifdef MEM_ARB_STARVE_GUARD_EN
    parameter int MAX_CPU_RUN = 4,
`endif
    localparam int ADDR_W = $clog2(RAM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_stall,

    input  logic                 ldr_req,
    input  logic                 ldr_we,
    input  logic [ADDR_W-1:0]    ldr_addr,
    input  logic [WORD_SIZE-1:0] ldr_wdata,
    output logic [WORD_SIZE-1:0] ldr_rdata,
    output logic                 ldr_ready,

    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    input  logic [WORD_SIZE-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    state_t                state, state_nxt;
    owner_t                own;
    logic                  cmd_we;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [WORD_SIZE-1:0]  cmd_wdata;
    logic [WORD_SIZE-1:0]  cpu_rdata_q;
    logic [WORD_SIZE-1:0]  ldr_rdata_q;

    logic                  force_ldr;
    logic                  grant_cpu;
    logic                  grant_ldr;

    // Grant terms are only acted on in IDLE.
    assign grant_cpu = cpu_req & ~force_ldr;
    assign grant_ldr = ldr_req & ~grant_cpu;

    // -------------------------------------------------------------------------
    // Loader starvation guard
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int RUN_W = (MAX_CPU_RUN < 1) ? 1 : $clog2(MAX_CPU_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

    logic [RUN_W-1:0] run_cnt;

    assign force_ldr = (run_cnt == RUN_MAX) & ldr_req;

    // Counts CPU grants taken while the loader waits; saturates at RUN_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (grant_ldr || !ldr_req) begin
                run_cnt <= '0;
            end else if (grant_cpu && run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end
`else
    assign force_ldr = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_cpu || grant_ldr) state_nxt = S_ACC;
            S_ACC:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned; otherwise synthesis infers a latch to hold it.
    always_comb begin
        ram_en    = 1'b0;
        cpu_ready = 1'b0;
        ldr_ready = 1'b0;
        cpu_rdata = cpu_rdata_q;
        ldr_rdata = ldr_rdata_q;
        // Gated by rst so a reset landing in ACC never writes the RAM and a
        // reset landing in DONE never reports completion.
        if (!rst) begin
            case (state)
                S_ACC: ram_en = 1'b1;
                S_DONE: begin
                    if (own == OWN_CPU) begin
                        cpu_ready = 1'b1;
                        // RAM data arrives this cycle; forward it so rdata is
                        // valid alongside ready, and the register holds it after.
                        if (!cmd_we) cpu_rdata = ram_rdata;
                    end else begin
                        ldr_ready = 1'b1;
                        if (!cmd_we) ldr_rdata = ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_we    = ram_en & cmd_we;
    assign ram_addr  = cmd_addr;
    assign ram_wdata = cmd_wdata;
    assign cpu_stall = cpu_req & ~cpu_ready;

    // -------------------------------------------------------------------------
    // Command latch and read-data hold registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            own         <= OWN_CPU;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (grant_cpu) begin
                    own       <= OWN_CPU;
                    cmd_we    <= cpu_we;
                    cmd_addr  <= cpu_addr;
                    cmd_wdata <= cpu_wdata;
                end else if (grant_ldr) begin
                    own       <= OWN_LDR;
                    cmd_we    <= ldr_we;
                    cmd_addr  <= ldr_addr;
                    cmd_wdata <= ldr_wdata;
                end
            end
            if (state == S_DONE && !cmd_we) begin
                if (own == OWN_CPU) cpu_rdata_q <= ram_rdata;
                else                ldr_rdata_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a synchronous RAM attached. A
// transaction-level model (grant at cycle N, strobe at N+1, completion at N+2)
// predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MAX_RUN = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_stall;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [9:0]  ldr_addr = '0;
    logic [31:0] ldr_wdata = '0;
    logic [31:0] ldr_rdata;
    logic        ldr_ready;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_stall (cpu_stall),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_rdata (ldr_rdata),
        .ldr_ready (ldr_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM with one-cycle synchronous read.
    // NOTE: the storage array has no reset; its contents survive rst, which is
    // what the reset-during-write test relies on.
    logic [31:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Transaction model: age = cycles since grant (-1 = free), plus a
    // reference copy of RAM contents.
    // -------------------------------------------------------------------------
    logic [31:0] ref_mem [1024];
    int          age = -1;
    bit          m_ldr = 1'b0;
    bit          m_we = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    int          run = 0;

    always @(posedge clk) begin
        bit force_l, g_cpu, g_ldr;
        if (rst) begin
            age = -1; m_ldr = 1'b0; run = 0;
            exp_rd[0] = '0; exp_rd[1] = '0;
        end else if (age == -1) begin
            force_l = GUARD && (run == MAX_RUN) && ldr_req;
            g_cpu   = cpu_req && !force_l;
            g_ldr   = !g_cpu && ldr_req;
            if (g_cpu) begin
                age = 1; m_ldr = 1'b0; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
            end else if (g_ldr) begin
                age = 1; m_ldr = 1'b1; m_we = ldr_we; m_addr = ldr_addr; m_wdata = ldr_wdata;
            end
            if (!ldr_req || g_ldr)            run = 0;
            else if (g_cpu && run < MAX_RUN) run = run + 1;
        end else if (age == 1) begin
            age = 2;
            if (m_we) ref_mem[m_addr] = m_wdata;
        end else begin
            if (!m_we) exp_rd[m_ldr] = ref_mem[m_addr];
            age = -1;
        end
    end

    // Observed completion history.
    int    cpu_cnt = 0, ldr_cnt = 0;
    int    cpu_last = 0, ldr_last = 0;
    string gseq = "";

    always @(negedge clk) begin
        bit          e_en, e_cr, e_lr;
        logic [31:0] e_crd, e_lrd;
        if (cmp_en) begin
            e_en  = (age == 1) && !rst;
            e_cr  = (age == 2) && !m_ldr && !rst;
            e_lr  = (age == 2) && m_ldr && !rst;
            e_crd = (e_cr && !m_we) ? ref_mem[m_addr] : exp_rd[0];
            e_lrd = (e_lr && !m_we) ? ref_mem[m_addr] : exp_rd[1];
            check("ram_en", 32'(ram_en), 32'(e_en));
            check("ram_we", 32'(ram_we), 32'(e_en && m_we));
            if (e_en) check("ram_addr", 32'(ram_addr), 32'(m_addr));
            if (e_en && m_we) check("ram_wdata", ram_wdata, m_wdata);
            check("cpu_ready", 32'(cpu_ready), 32'(e_cr));
            check("ldr_ready", 32'(ldr_ready), 32'(e_lr));
            check("cpu_rdata", cpu_rdata, e_crd);
            check("ldr_rdata", ldr_rdata, e_lrd);
            check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cr));
            if (cpu_ready === 1'b1) begin cpu_cnt++; cpu_last = cyc; gseq = {gseq, "C"}; end
            if (ldr_ready === 1'b1) begin ldr_cnt++; ldr_last = cyc; gseq = {gseq, "L"}; end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_ldr);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_ldr ? ldr_ready : cpu_ready) && n < 20);
        check(is_ldr ? "ldr_ready_seen" : "cpu_ready_seen",
              32'(is_ldr ? ldr_ready : cpu_ready), 32'd1);
    endtask

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic access(input bit is_ldr, input bit we, input logic [9:0] addr,
                          input logic [31:0] wd);
        if (is_ldr) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd; end
        else        begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        wait_ready(is_ldr);
        step();
        if (is_ldr) ldr_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int c0, l0;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        ram_mem[5] = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;

        // Reset
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ram_en",    32'(ram_en), 32'd0);
        check("rst_ram_addr",  32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_ldr_rdata", ldr_rdata, 32'd0);
        check("rst_readies",   32'({cpu_ready, ldr_ready}), 32'd0);

        // CPU read of address 5, cycle-exact
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        @(negedge clk);
        check("c0_stall",  32'(cpu_stall), 32'd1);
        check("c0_ram_en", 32'(ram_en), 32'd0);
        step();
        @(negedge clk);
        check("c1_ram_en",   32'(ram_en), 32'd1);
        check("c1_ram_addr", 32'(ram_addr), 32'h005);
        check("c1_stall",    32'(cpu_stall), 32'd1);
        step();
        @(negedge clk);
        check("c2_ready", 32'(cpu_ready), 32'd1);
        check("c2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("c2_stall", 32'(cpu_stall), 32'd0);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("c3_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
        check("c3_ready_low",  32'(cpu_ready), 32'd0);
        step();

        // Loader write 0x3FF, then CPU reads it back
        l0 = ldr_cnt;
        access(1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
        access(1'b0, 1'b0, 10'h3FF, 32'h0);
        @(negedge clk);
        check("ldr_wr_readback", cpu_rdata, 32'h1234_5678);
        check("ldr_wr_pulses",   32'(ldr_cnt - l0), 32'd1);
        check("ldr_rdata_after_write", ldr_rdata, 32'd0);
        step();

        // Simultaneous requests: CPU first, loader three cycles later
        c0 = cpu_cnt; l0 = ldr_cnt; gseq = "";
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'h3FF;
        wait_ready(1'b0);
        step();
        cpu_req = 1'b0;
        wait_ready(1'b1);
        step();
        ldr_req = 1'b0;
        check_str("simul_order", gseq, "CL");
        check("simul_gap", 32'(ldr_last - cpu_last), 32'd3);
        check("simul_cpu_pulses", 32'(cpu_cnt - c0), 32'd1);
        check("simul_ldr_pulses", 32'(ldr_cnt - l0), 32'd1);
        check("simul_ldr_rdata", ldr_rdata, 32'h1234_5678);
        step();

        // Both requests held: guard forces every fifth grant to the loader
        gseq = "";
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'h3FF;
        repeat (18) step();
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (4) step();
        check_str("held_grant_seq", gseq, GUARD ? "CCCCLC" : "CCCCCC");

        // Reset during ACC of a CPU write to 0x010
        c0 = cpu_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 32'hCAFE_F00D;
        step();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("rst_acc_ram_en", 32'(ram_en), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs",
              32'({ram_en, ram_we, cpu_ready, ldr_ready, cpu_stall}), 32'd0);
        check("post_rst_ram_addr",  32'(ram_addr), 32'd0);
        check("post_rst_ram_wdata", ram_wdata, 32'd0);
        check("post_rst_cpu_rdata", cpu_rdata, 32'd0);
        check("post_rst_ldr_rdata", ldr_rdata, 32'd0);
        repeat (3) step();
        check("rst_ram_unchanged", ram_mem[16], 32'hA5A5_0010);
        check("rst_no_cpu_ready",  32'(cpu_cnt - c0), 32'd0);

        // Loader drops its request during ACC; access still completes
        l0 = ldr_cnt;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'h3FF;
        step();
        ldr_req = 1'b0;
        @(negedge clk);
        check("drop_ram_en", 32'(ram_en), 32'd1);
        step();
        @(negedge clk);
        check("drop_ready", 32'(ldr_ready), 32'd1);
        check("drop_rdata", ldr_rdata, 32'h1234_5678);
        step();
        @(negedge clk);
        check("drop_ready_once", 32'(ldr_cnt - l0), 32'd1);

        // Arbiter back in IDLE: fresh CPU access completes normally
        step();
        access(1'b0, 1'b0, 10'h005, 32'h0);
        @(negedge clk);
        check("final_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
